// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - opcode constants, sequencer states and opcode classing for the mini-SRC control unit
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Opcodes sharing an identical execute sequence collapse into one class
  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_t;

  function automatic op_class_t decode_op(input logic [4:0] op);
    case (op)
      OP_LD:                                    return C_LD;
      OP_LDI:                                   return C_LDI;
      OP_ST:                                    return C_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:            return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:                 return C_IMM;
      OP_MUL, OP_DIV:                           return C_MULDIV;
      OP_NEG, OP_NOT:                           return C_NEGNOT;
      OP_BR:                                    return C_BR;
      OP_JR:                                    return C_JR;
      OP_JAL:                                   return C_JAL;
      OP_IN:                                    return C_IN;
      OP_OUT:                                   return C_OUT;
      OP_MFHI:                                  return C_MFHI;
      OP_MFLO:                                  return C_MFLO;
      OP_HALT:                                  return C_HALT;
      default:                                  return C_NOP;
    endcase
  endfunction

  function automatic state_t last_step(input op_class_t cls);
    case (cls)
      C_NEGNOT, C_JAL:               return S_T4;
      C_ALU, C_IMM, C_LDI:           return S_T5;
      C_MULDIV, C_BR:                return S_T6;
      C_LD, C_ST:                    return S_T7;
      default:                       return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore control sequencer stepping the mini-SRC datapath through fetch and execute
module control_unit
  import cpu_defs_pkg::*;
(
  input  logic       Clock,
  input  logic       Clear,
  input  logic [4:0] opcode,
  input  logic       CON,
  input  logic       Stop,
  output logic       PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout,
  output logic       PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn, Rin, LinkIn,
  output logic       GRA, GRB, GRC,
  output logic       IncPC, ForceAdd,
  output logic       Read, Write,
  output logic       Run
);

  state_t    state, next_state;
  op_class_t cls;

  assign cls = decode_op(opcode);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= S_RESET;
    else        state <= next_state;
  end

  // Stop is only honoured at an instruction boundary so the current instruction completes
  always_comb begin
    next_state = state;
    case (state)
      S_RESET: next_state = S_T0;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = S_T2;
      S_T2:    next_state = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state >= last_step(cls)) begin
          if (cls == C_HALT || Stop) next_state = S_HALT;
          else                       next_state = S_T0;
        end else begin
          next_state = state_t'(state + 4'd1);
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RESET;
    endcase
  end

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; Cout = 1'b0; InPortOut = 1'b0; BAout = 1'b0; Rout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; ZLowIn = 1'b0;
    ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; OutPortIn = 1'b0;
    Rin = 1'b0; LinkIn = 1'b0; GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
    IncPC = 1'b0; ForceAdd = 1'b0; Read = 1'b0; Write = 1'b0;
    Run = (state != S_RESET) && (state != S_HALT);

    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (cls)
          C_ALU, C_IMM: begin
            case (state)
              S_T3: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4: begin
                ZLowIn = 1'b1;
                if (cls == C_ALU) begin GRC = 1'b1; Rout = 1'b1; end
                else              Cout = 1'b1;
              end
              S_T5: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4: begin GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
              S_T5: begin ZLowout = 1'b1; LOin = 1'b1; end
              S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          end
          C_NEGNOT: begin
            case (state)
              S_T3: begin GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
              S_T4: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          // ldi, ld and st share the base+offset address computation
          C_LDI, C_LD, C_ST: begin
            case (state)
              S_T3: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              S_T4: begin Cout = 1'b1; ForceAdd = 1'b1; ZLowIn = 1'b1; end
              S_T5: begin
                ZLowout = 1'b1;
                if (cls == C_LDI) begin GRA = 1'b1; Rin = 1'b1; end
                else              MARin = 1'b1;
              end
              S_T6: begin
                MDRin = 1'b1;
                if (cls == C_LD) Read = 1'b1;
                else begin GRA = 1'b1; Rout = 1'b1; end
              end
              S_T7: begin
                if (cls == C_LD) begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                else             Write = 1'b1;
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (state)
              S_T3: begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              S_T4: begin PCout = 1'b1; Yin = 1'b1; end
              S_T5: begin Cout = 1'b1; ForceAdd = 1'b1; ZLowIn = 1'b1; end
              S_T6: begin ZLowout = 1'b1; PCin = CON; end
              default: ;
            endcase
          end
          C_JR:   if (state == S_T3) begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL: begin
            if (state == S_T3) begin PCout = 1'b1; LinkIn = 1'b1; end
            if (state == S_T4) begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          end
          C_IN:   if (state == S_T3) begin InPortOut = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_OUT:  if (state == S_T3) begin GRA = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          C_MFHI: if (state == S_T3) begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_MFLO: if (state == S_T3) begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven bench for control_unit plus reset, halt and Stop sequences
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Clear = 1'b1;
  logic [4:0] opcode = 5'b0;
  logic       CON = 1'b0;
  logic       Stop = 1'b0;
  logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn, Rin, LinkIn;
  logic GRA, GRB, GRC, IncPC, ForceAdd, Read, Write, Run;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .opcode(opcode), .CON(CON), .Stop(Stop),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn),
    .Rin(Rin), .LinkIn(LinkIn), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .IncPC(IncPC), .ForceAdd(ForceAdd), .Read(Read), .Write(Write), .Run(Run)
  );

  always #5 Clock = ~Clock;

  // Bits 30..21 are the bus drivers
  logic [30:0] ctl;
  assign ctl = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout,
                PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn,
                Rin, LinkIn, GRA, GRB, GRC, IncPC, ForceAdd, Read, Write, Run};

  localparam logic [30:0] PCOUT = 31'd1 << 30, ZHIGHOUT = 31'd1 << 29, ZLOWOUT = 31'd1 << 28,
    MDROUT = 31'd1 << 27, HIOUT = 31'd1 << 26, LOOUT = 31'd1 << 25, COUT = 31'd1 << 24,
    INPORTOUT = 31'd1 << 23, BAOUT = 31'd1 << 22, ROUT = 31'd1 << 21, PCIN = 31'd1 << 20,
    IRIN = 31'd1 << 19, MARIN = 31'd1 << 18, MDRIN = 31'd1 << 17, YIN = 31'd1 << 16,
    ZLOWIN = 31'd1 << 15, ZHIGHIN = 31'd1 << 14, HIIN = 31'd1 << 13, LOIN = 31'd1 << 12,
    CONIN = 31'd1 << 11, OUTPORTIN = 31'd1 << 10, RIN = 31'd1 << 9, LINKIN = 31'd1 << 8,
    GRA_M = 31'd1 << 7, GRB_M = 31'd1 << 6, GRC_M = 31'd1 << 5, INCPC = 31'd1 << 4,
    FORCEADD = 31'd1 << 3, READ = 31'd1 << 2, WRITE = 31'd1 << 1, RUN = 31'd1;

  localparam logic [30:0] W_T0 = PCOUT | MARIN | INCPC | ZLOWIN | RUN;
  localparam logic [30:0] W_T1 = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [30:0] W_T2 = MDROUT | IRIN | RUN;

  typedef struct {
    logic [4:0]  op;
    logic        con;
    int          cycles;
    logic [30:0] e3, e4, e5, e6, e7;
  } vec_t;

  vec_t vecs [18];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [30:0] exp);
    checks++;
    if (ctl !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, ctl, exp);
    end
    checks++;
    if ($countones(ctl[30:21]) > 1) begin
      errors++;
      $display("FAIL %s bus drivers got %b want at most one high", name, ctl[30:21]);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [4:0] op, input logic con, input int cyc,
                         input logic [30:0] e3, input logic [30:0] e4, input logic [30:0] e5,
                         input logic [30:0] e6, input logic [30:0] e7);
    vecs[i].op = op; vecs[i].con = con; vecs[i].cycles = cyc;
    vecs[i].e3 = e3; vecs[i].e4 = e4; vecs[i].e5 = e5; vecs[i].e6 = e6; vecs[i].e7 = e7;
  endtask

  initial begin
    logic [30:0] e;
    set_vec(0,  5'b00011, 0, 6, GRB_M|ROUT|YIN, GRC_M|ROUT|ZLOWIN, ZLOWOUT|GRA_M|RIN, 0, 0);
    set_vec(1,  5'b01000, 0, 6, GRB_M|ROUT|YIN, GRC_M|ROUT|ZLOWIN, ZLOWOUT|GRA_M|RIN, 0, 0);
    set_vec(2,  5'b01011, 0, 6, GRB_M|ROUT|YIN, COUT|ZLOWIN, ZLOWOUT|GRA_M|RIN, 0, 0);
    set_vec(3,  5'b01110, 0, 7, GRA_M|ROUT|YIN, GRB_M|ROUT|ZLOWIN|ZHIGHIN, ZLOWOUT|LOIN, ZHIGHOUT|HIIN, 0);
    set_vec(4,  5'b10000, 0, 5, GRB_M|ROUT|ZLOWIN, ZLOWOUT|GRA_M|RIN, 0, 0, 0);
    set_vec(5,  5'b00001, 0, 6, GRB_M|BAOUT|YIN, COUT|FORCEADD|ZLOWIN, ZLOWOUT|GRA_M|RIN, 0, 0);
    set_vec(6,  5'b00000, 0, 8, GRB_M|BAOUT|YIN, COUT|FORCEADD|ZLOWIN, ZLOWOUT|MARIN, READ|MDRIN, MDROUT|GRA_M|RIN);
    set_vec(7,  5'b00010, 0, 8, GRB_M|BAOUT|YIN, COUT|FORCEADD|ZLOWIN, ZLOWOUT|MARIN, GRA_M|ROUT|MDRIN, WRITE);
    set_vec(8,  5'b10010, 0, 7, GRA_M|ROUT|CONIN, PCOUT|YIN, COUT|FORCEADD|ZLOWIN, ZLOWOUT, 0);
    set_vec(9,  5'b10010, 1, 7, GRA_M|ROUT|CONIN, PCOUT|YIN, COUT|FORCEADD|ZLOWIN, ZLOWOUT|PCIN, 0);
    set_vec(10, 5'b10011, 0, 4, GRA_M|ROUT|PCIN, 0, 0, 0, 0);
    set_vec(11, 5'b10100, 0, 5, PCOUT|LINKIN, GRA_M|ROUT|PCIN, 0, 0, 0);
    set_vec(12, 5'b10101, 0, 4, INPORTOUT|GRA_M|RIN, 0, 0, 0, 0);
    set_vec(13, 5'b10110, 0, 4, GRA_M|ROUT|OUTPORTIN, 0, 0, 0, 0);
    set_vec(14, 5'b10111, 0, 4, HIOUT|GRA_M|RIN, 0, 0, 0, 0);
    set_vec(15, 5'b11000, 0, 4, LOOUT|GRA_M|RIN, 0, 0, 0, 0);
    set_vec(16, 5'b11001, 0, 4, 0, 0, 0, 0, 0);
    set_vec(17, 5'b11111, 0, 4, 0, 0, 0, 0, 0);

    #3 Clear = 1'b0;
    #1 check("reset_async", 0);
    tick();
    check("reset_held", 0);
    Clear = 1'b1;
    tick();
    check("first_t0", W_T0);

    for (int i = 0; i < 18; i++) begin
      opcode = vecs[i].op;
      CON = vecs[i].con;
      tick(); check($sformatf("v%0d T1", i), W_T1);
      tick(); check($sformatf("v%0d T2", i), W_T2);
      for (int t = 3; t < vecs[i].cycles; t++) begin
        case (t)
          3: e = vecs[i].e3;
          4: e = vecs[i].e4;
          5: e = vecs[i].e5;
          6: e = vecs[i].e6;
          default: e = vecs[i].e7;
        endcase
        tick(); check($sformatf("v%0d T%0d", i, t), e | RUN);
      end
      tick(); check($sformatf("v%0d next_T0", i), W_T0);
    end

    // Clear asserted in T4 of ld, away from any clock edge
    opcode = 5'b00000;
    tick(); tick(); tick(); tick();
    check("ld T4 before clear", COUT | FORCEADD | ZLOWIN | RUN);
    #2 Clear = 1'b0;
    #1 check("clear_mid_ld", 0);
    tick(); check("clear_mid_ld_held", 0);
    Clear = 1'b1;
    tick(); check("after_clear_T0", W_T0);

    // halt instruction
    opcode = 5'b11010;
    tick(); tick(); tick();
    check("halt T3", RUN);
    tick(); check("halt_state", 0);
    tick(); tick(); check("halt_stays", 0);

    Clear = 1'b0;
    #2 Clear = 1'b1;
    tick(); check("restart_T0", W_T0);

    // Stop raised mid-mul: instruction completes, then HALT
    opcode = 5'b01110;
    tick(); tick(); tick();
    Stop = 1'b1;
    tick(); check("stop mul T4", GRB_M | ROUT | ZLOWIN | ZHIGHIN | RUN);
    tick(); check("stop mul T5", ZLOWOUT | LOIN | RUN);
    tick(); check("stop mul T6", ZHIGHOUT | HIIN | RUN);
    tick(); check("stop_halt", 0);
    Stop = 1'b0;
    tick(); tick(); check("stop_halt_stays", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
